// File: rtl/ppio_state_scan_ctrl_if.sv
// Host-side bus of the PPI/PPO state scan controller: command, load-word and unload-word channels.
// The slave modport is the controller's view, and the master modport is the host's view.
interface ppio_state_scan_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [CNT_W-1:0]  cmd_arg_i;
  logic [WORD_W-1:0] wr_data_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [WORD_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_arg_i, wr_data_i, wr_valid_i, rd_ready_i,
    output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_arg_i, wr_data_i, wr_valid_i, rd_ready_i,
    input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/ppio_state_scan_ctrl.sv
// Holds the extracted flop state: it drives the PPIs, captures the PPOs for N cycles,
// and supports word-serial load and unload of the whole state vector by the host.
module ppio_state_scan_ctrl #(
  parameter int STATE_W = 64,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic [STATE_W-1:0]    ppo_i,
  output logic [STATE_W-1:0]    ppi_o,
  output logic                  busy_o,
  output logic                  done_o,
  ppio_state_scan_ctrl_if.slave bus
);

  localparam int NWORDS = (STATE_W + WORD_W - 1) / WORD_W;
  localparam int EXT_W  = NWORDS * WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_UNLOAD = 2'b10;
  localparam logic [1:0] OP_RUN    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2,
    ST_RUN    = 2'd3
  } fsm_t;

  fsm_t               fsm_q,      fsm_d;
  logic [STATE_W-1:0] state_q,    state_d;
  logic [EXT_W-1:0]   snap_q,     snap_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WORD_W-1:0]  rd_data_q,  rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q,     done_d;

  logic [EXT_W-1:0]   ext_s;
  logic [IDX_W-1:0]   idx_nxt_s;

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      fsm_q      <= ST_IDLE;
      state_q    <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    idx_nxt_s  = idx_q + IDX_W'(1);
    // The state is zero-padded to whole words, so a load of the top word drops bits above STATE_W.
    ext_s                = '0;
    ext_s[STATE_W-1:0]   = state_q;

    case (fsm_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          case (bus.cmd_op_i)
            OP_LOAD: begin
              fsm_d = ST_LOAD;
              idx_d = '0;
            end
            OP_UNLOAD: begin
              fsm_d      = ST_UNLOAD;
              idx_d      = '0;
              snap_d     = ext_s;
              rd_data_d  = ext_s[WORD_W-1:0];
              rd_valid_d = 1'b1;
            end
            OP_RUN: begin
              if (bus.cmd_arg_i == '0) begin
                done_d = 1'b1;
              end else begin
                cnt_d = bus.cmd_arg_i;
                fsm_d = ST_RUN;
              end
            end
            OP_NOP: begin
              fsm_d = ST_IDLE;
            end
            default: begin
              fsm_d = ST_IDLE;
            end
          endcase
        end else begin
          fsm_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (bus.wr_valid_i) begin
          for (int w = 0; w < NWORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
              ext_s[w*WORD_W +: WORD_W] = bus.wr_data_i;
            end else begin
              ext_s[w*WORD_W +: WORD_W] = ext_s[w*WORD_W +: WORD_W];
            end
          end
          state_d = ext_s[STATE_W-1:0];
          if (idx_q == LAST_IDX) begin
            fsm_d  = ST_IDLE;
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_nxt_s;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      ST_UNLOAD: begin
        if (rd_valid_q && bus.rd_ready_i) begin
          if (idx_q == LAST_IDX) begin
            fsm_d      = ST_IDLE;
            idx_d      = '0;
            rd_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d = idx_nxt_s;
            for (int w = 0; w < NWORDS; w++) begin
              if (idx_nxt_s == IDX_W'(w)) begin
                rd_data_d = snap_q[w*WORD_W +: WORD_W];
              end else begin
                rd_data_d = rd_data_d;
              end
            end
          end
        end else begin
          idx_d = idx_q;
        end
      end

      ST_RUN: begin
        // Every edge spent in RUN is one capture, so N cycles give exactly N captures.
        state_d = ppo_i;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fsm_d  = ST_IDLE;
          done_d = 1'b1;
        end else begin
          fsm_d = ST_RUN;
        end
      end

      default: begin
        fsm_d      = ST_IDLE;
        rd_valid_d = 1'b0;
      end
    endcase
  end

  assign ppi_o           = state_q;
  assign busy_o          = (fsm_q != ST_IDLE);
  assign done_o          = done_q;
  assign bus.cmd_ready_o = (fsm_q == ST_IDLE);
  assign bus.wr_ready_o  = (fsm_q == ST_LOAD);
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_ppio_state_scan_ctrl.sv
// Scoreboard bench for ppio_state_scan_ctrl: a 64-bit instance gets directed and random traffic,
// and a 40-bit instance gets a short padding sequence.
module tb_ppio_state_scan_ctrl;
  localparam int STATE_W = 64;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 16;
  localparam int NWORDS  = 2;

  logic CLK = 1'b0;
  logic RSTB = 1'b0;
  always #5 CLK = ~CLK;

  logic [STATE_W-1:0] ppo, ppi;
  logic               busy, done;
  bit                 cone_inc = 1'b1;

  logic [39:0] p_ppi;
  logic        p_busy, p_done;

  ppio_state_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();
  ppio_state_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) pbus ();

  ppio_state_scan_ctrl #(.STATE_W(STATE_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTB(RSTB), .ppo_i(ppo), .ppi_o(ppi), .busy_o(busy), .done_o(done), .bus(bus)
  );

  ppio_state_scan_ctrl #(.STATE_W(40), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_pad (
    .CLK(CLK), .RSTB(RSTB), .ppo_i(p_ppi), .ppi_o(p_ppi), .busy_o(p_busy), .done_o(p_done), .bus(pbus)
  );

  // The bench's stand-in for the combinational cone.
  function automatic logic [63:0] cone_f(input logic [63:0] s, input bit inc);
    if (inc) return s + 64'd1;
    return {s[62:0], s[63]} ^ 64'h9E3779B97F4A7C15;
  endfunction

  assign ppo = cone_f(ppi, cone_inc);

  int checks = 0;
  int errors = 0;
  logic [63:0] model_q = 64'd0;
  logic [31:0] exp_rd[$];
  logic [63:0] exp_done[$];
  bit mon_en = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen or bound expired, required otherwise", name);
  endfunction

  // Monitor: handles rd words, done pulses and the hold rule under backpressure.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;
    forever begin
      @(negedge CLK);
      if (RSTB && mon_en) begin
        if (prev_stall) begin
          check("rd_hold_valid", {63'd0, bus.rd_valid_o}, 64'd1);
          check("rd_hold_data", {32'd0, bus.rd_data_o}, {32'd0, prev_data});
        end
        prev_stall = bus.rd_valid_o && !bus.rd_ready_i;
        prev_data  = bus.rd_data_o;
        if (bus.rd_valid_o && bus.rd_ready_i) begin
          if (exp_rd.size() == 0) fail("rd_unexpected_word");
          else check("rd_word", {32'd0, bus.rd_data_o}, {32'd0, exp_rd.pop_front()});
        end
        if (done) begin
          if (exp_done.size() == 0) fail("done_unexpected");
          else check("done_state", ppi, exp_done.pop_front());
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    bit ok = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_arg_i   = arg;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.cmd_ready_o;
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      ok = !busy;
    end
    tick();
    if (!ok) fail("idle_timeout");
  endtask

  task automatic do_load(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] words[2];
    words[0] = w0;
    words[1] = w1;
    issue(2'b01, 16'd0);
    for (int w = 0; w < NWORDS; w++) begin
      bit ok = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      model_q[w*32 +: 32] = words[w];
      if (w == NWORDS - 1) exp_done.push_back(model_q);
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = words[w];
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge CLK);
        ok = bus.wr_ready_o;
        tick();
      end
      bus.wr_valid_i = 1'b0;
      bus.wr_data_i  = $urandom;
      if (!ok) fail("wr_accept_timeout");
    end
    wait_idle();
  endtask

  task automatic do_unload(input bit stall3);
    int n = 0;
    int cyc = 0;
    exp_rd.push_back(model_q[31:0]);
    exp_rd.push_back(model_q[63:32]);
    exp_done.push_back(model_q);
    issue(2'b10, 16'd0);
    while (n < NWORDS && cyc < 200) begin
      bus.rd_ready_i  = (stall3 && cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.cmd_valid_i = 1'($urandom_range(0, 1));
      bus.cmd_op_i    = 2'b11;
      bus.cmd_arg_i   = 16'd3;
      @(negedge CLK);
      if (bus.rd_valid_o && bus.rd_ready_i) n++;
      tick();
      cyc++;
    end
    bus.rd_ready_i  = 1'b0;
    bus.cmd_valid_i = 1'b0;
    if (n < NWORDS) fail("rd_word_timeout");
    wait_idle();
  endtask

  task automatic do_run(input logic [15:0] n, input bit inc);
    logic [63:0] e = model_q;
    for (int i = 0; i < int'(n); i++) e = cone_f(e, inc);
    exp_done.push_back(e);
    cone_inc = inc;
    issue(2'b11, n);
    model_q = e;
    wait_idle();
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00; bus.cmd_arg_i = 16'd0;
    bus.wr_valid_i = 1'b0; bus.wr_data_i = 32'd0; bus.rd_ready_i = 1'b0;
    pbus.cmd_valid_i = 1'b0; pbus.cmd_op_i = 2'b00; pbus.cmd_arg_i = 16'd0;
    pbus.wr_valid_i = 1'b0; pbus.wr_data_i = 32'd0; pbus.rd_ready_i = 1'b0;

    // Reset held for two edges, checked after the first one.
    tick();
    check("rst_ppi", ppi, 64'd0);
    check("rst_rd_valid", {63'd0, bus.rd_valid_o}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cmd_ready", {63'd0, bus.cmd_ready_o}, 64'd1);
    tick();
    RSTB   = 1'b1;
    mon_en = 1'b1;

    // Directed round trip with a stalled unload.
    do_load(32'hDEADBEEF, 32'h01234567);
    check("load_ppi", ppi, 64'h01234567DEADBEEF);
    do_unload(1'b1);
    check("unload_keeps_ppi", ppi, 64'h01234567DEADBEEF);

    // RUN timing with the incrementing cone.
    do_load(32'd0, 32'd0);
    cone_inc = 1'b1;
    exp_done.push_back(64'd5);
    issue(2'b11, 16'd5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      check("run5_ppi", ppi, (k <= 5) ? 64'(k - 1) : 64'd5);
      check("run5_done", {63'd0, done}, (k == 6) ? 64'd1 : 64'd0);
      check("run5_busy", {63'd0, busy}, (k == 6) ? 64'd0 : 64'd1);
    end
    tick();
    model_q = 64'd5;
    exp_done.push_back(64'd5);
    issue(2'b11, 16'd0);
    @(negedge CLK);
    check("run0_done", {63'd0, done}, 64'd1);
    check("run0_ppi", ppi, 64'd5);
    tick();
    @(negedge CLK);
    check("run0_single_pulse", {63'd0, done}, 64'd0);
    tick();

    // Reset in the middle of a LOAD.
    issue(2'b01, 16'd0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'h13579BDF;
    tick();
    bus.wr_valid_i = 1'b0;
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    check("midrst_ppi", ppi, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    @(negedge CLK);
    check("midrst_no_done", {63'd0, done}, 64'd0);
    tick();
    model_q = 64'd0;
    do_load(32'hCAFEF00D, 32'h0BADC0DE);
    check("postrst_load_ppi", ppi, 64'h0BADC0DECAFEF00D);

    // Random traffic against the model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_load($urandom, $urandom);
        1: do_unload(1'b0);
        2: do_run(16'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        default: begin
          issue(2'b00, 16'($urandom));
          @(negedge CLK);
          check("nop_idle", {63'd0, busy}, 64'd0);
          tick();
        end
      endcase
      check("model_ppi", ppi, model_q);
    end

    // Padding on the 40-bit instance.
    pbus.cmd_valid_i = 1'b1;
    pbus.cmd_op_i    = 2'b01;
    tick();
    pbus.cmd_valid_i = 1'b0;
    pbus.wr_valid_i  = 1'b1;
    pbus.wr_data_i   = 32'hAAAAAAAA;
    tick();
    pbus.wr_data_i   = 32'hFFFFFF55;
    tick();
    pbus.wr_valid_i  = 1'b0;
    @(negedge CLK);
    check("pad_done", {63'd0, p_done}, 64'd1);
    check("pad_ppi", {24'd0, p_ppi}, 64'h00000055AAAAAAAA);
    tick();
    pbus.cmd_valid_i = 1'b1;
    pbus.cmd_op_i    = 2'b10;
    tick();
    pbus.cmd_valid_i = 1'b0;
    @(negedge CLK);
    check("pad_rd0_valid", {63'd0, pbus.rd_valid_o}, 64'd1);
    check("pad_rd0", {32'd0, pbus.rd_data_o}, 64'h00000000AAAAAAAA);
    pbus.rd_ready_i = 1'b1;
    tick();
    @(negedge CLK);
    check("pad_rd1", {32'd0, pbus.rd_data_o}, 64'h0000000000000055);
    tick();
    pbus.rd_ready_i = 1'b0;
    @(negedge CLK);
    check("pad_rd_done_valid", {63'd0, pbus.rd_valid_o}, 64'd0);
    check("pad_unload_done", {63'd0, p_done}, 64'd1);
    tick();

    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
